// File: rtl/salsa20_8_core_if.sv
// Block-level handshake bundle for the Salsa20/8 core: input block channel,
// result channel and the busy indicator.
interface salsa20_8_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;
   logic         busy;

   // Upstream/downstream side (BlockMix sequencer and output buffer)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   // Core side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/salsa20_8_core.sv
// Iterative Salsa20/8 core: one half-round (column or row) per clock using four
// parallel quarter-round units, then a word-wise feed-forward add of the input.
module salsa20_8_core #(
   parameter int unsigned ROUNDS = 8,
   parameter int unsigned CNT_W  = 4
) (
   input logic             clk,
   input logic             rst_n,
   salsa20_8_core_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ROUNDS - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      x_q [16];
   logic [31:0]      z_q [16];
   logic [31:0]      r   [16];
   logic [511:0]     out_data_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             out_valid_q;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
      return (v << s) | (v >> (32 - s));
   endfunction

   // Returns {a, b, c, d} after one quarterround
   function automatic logic [127:0] quarter(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
      logic [31:0] a1, b1, c1, d1;
      b1 = b ^ rotl(a + d, 7);
      c1 = c ^ rotl(b1 + a, 9);
      d1 = d ^ rotl(c1 + b1, 13);
      a1 = a ^ rotl(d1 + c1, 18);
      return {a1, b1, c1, d1};
   endfunction

   // Half-round datapath: even counter selects column round, odd selects row round
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         r[i] = x_q[i];
      end
      if (!cnt_q[0]) begin
         {r[0],  r[4],  r[8],  r[12]} = quarter(x_q[0],  x_q[4],  x_q[8],  x_q[12]);
         {r[5],  r[9],  r[13], r[1]}  = quarter(x_q[5],  x_q[9],  x_q[13], x_q[1]);
         {r[10], r[14], r[2],  r[6]}  = quarter(x_q[10], x_q[14], x_q[2],  x_q[6]);
         {r[15], r[3],  r[7],  r[11]} = quarter(x_q[15], x_q[3],  x_q[7],  x_q[11]);
      end else begin
         {r[0],  r[1],  r[2],  r[3]}  = quarter(x_q[0],  x_q[1],  x_q[2],  x_q[3]);
         {r[5],  r[6],  r[7],  r[4]}  = quarter(x_q[5],  x_q[6],  x_q[7],  x_q[4]);
         {r[10], r[11], r[8],  r[9]}  = quarter(x_q[10], x_q[11], x_q[8],  x_q[9]);
         {r[15], r[12], r[13], r[14]} = quarter(x_q[15], x_q[12], x_q[13], x_q[14]);
      end
   end

   // Control FSM with registered handshake flags, working state and result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < 16; i++) begin
            x_q[i] <= '0;
            z_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.in_valid) begin
                  for (int i = 0; i < 16; i++) begin
                     x_q[i] <= bus_io.in_data[32*i +: 32];
                     z_q[i] <= bus_io.in_data[32*i +: 32];
                  end
                  cnt_q      <= '0;
                  state_q    <= StRound;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StRound: begin
               for (int i = 0; i < 16; i++) begin
                  x_q[i] <= r[i];
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  // Feed-forward: each word added independently, carries dropped
                  for (int i = 0; i < 16; i++) begin
                     out_data_q[32*i +: 32] <= r[i] + z_q[i];
                  end
                  state_q     <= StDone;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            StDone: begin
               // Output handshake wins; a pending in_valid waits for StIdle
               if (bus_io.out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;

endmodule

// File: tb/tb_salsa20_8_core.sv
// Self-checking bench for salsa20_8_core: random blocks scored against a
// straight-line Salsa20 reference, plus the RFC 7914 known-answer vector.
module tb_salsa20_8_core;

   localparam int unsigned R1 = 8;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   salsa20_8_core_if bus ();
   salsa20_8_core_if bus2 ();

   salsa20_8_core #(.ROUNDS(R1), .CNT_W(4)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   salsa20_8_core #(.ROUNDS(2), .CNT_W(2)) u_dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] kat_in_b [64] = '{
      8'h7e, 8'h87, 8'h9a, 8'h21, 8'h4f, 8'h3e, 8'hc9, 8'h86, 8'h7c, 8'ha9, 8'h40, 8'he6,
      8'h41, 8'h71, 8'h8f, 8'h26, 8'hba, 8'hee, 8'h55, 8'h5b, 8'h8c, 8'h61, 8'hc1, 8'hb5,
      8'h0d, 8'hf8, 8'h46, 8'h11, 8'h6d, 8'hcd, 8'h3b, 8'h1d, 8'hee, 8'h24, 8'hf3, 8'h19,
      8'hdf, 8'h9b, 8'h3d, 8'h85, 8'h14, 8'h12, 8'h1e, 8'h4b, 8'h5a, 8'hc5, 8'haa, 8'h32,
      8'h76, 8'h02, 8'h1d, 8'h29, 8'h09, 8'hc7, 8'h48, 8'h29, 8'hed, 8'heb, 8'hc6, 8'h8d,
      8'hb8, 8'hb8, 8'hc2, 8'h5e};
   logic [7:0] kat_out_b [64] = '{
      8'ha4, 8'h1f, 8'h85, 8'h9c, 8'h66, 8'h08, 8'hcc, 8'h99, 8'h3b, 8'h81, 8'hca, 8'hcb,
      8'h02, 8'h0c, 8'hef, 8'h05, 8'h04, 8'h4b, 8'h21, 8'h81, 8'ha2, 8'hfd, 8'h33, 8'h7d,
      8'hfd, 8'h7b, 8'h1c, 8'h63, 8'h96, 8'h68, 8'h2f, 8'h29, 8'hb4, 8'h39, 8'h31, 8'h68,
      8'he3, 8'hc9, 8'he6, 8'hbc, 8'hfe, 8'h6b, 8'hc5, 8'hb7, 8'ha0, 8'h6d, 8'h96, 8'hba,
      8'he4, 8'h24, 8'hcc, 8'h10, 8'h2c, 8'h91, 8'h74, 8'h5c, 8'h24, 8'had, 8'h67, 8'h3d,
      8'hc7, 8'h61, 8'h8f, 8'h81};

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] rl(input bit [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   // Reference Salsa20/r core in the classic straight-line form
   function automatic logic [511:0] salsa_ref(input logic [511:0] blk, input int rounds);
      bit [31:0]    x [16];
      logic [511:0] res;
      for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
      for (int n = rounds; n > 0; n -= 2) begin
         x[ 4] ^= rl(x[ 0] + x[12],  7);  x[ 8] ^= rl(x[ 4] + x[ 0],  9);
         x[12] ^= rl(x[ 8] + x[ 4], 13);  x[ 0] ^= rl(x[12] + x[ 8], 18);
         x[ 9] ^= rl(x[ 5] + x[ 1],  7);  x[13] ^= rl(x[ 9] + x[ 5],  9);
         x[ 1] ^= rl(x[13] + x[ 9], 13);  x[ 5] ^= rl(x[ 1] + x[13], 18);
         x[14] ^= rl(x[10] + x[ 6],  7);  x[ 2] ^= rl(x[14] + x[10],  9);
         x[ 6] ^= rl(x[ 2] + x[14], 13);  x[10] ^= rl(x[ 6] + x[ 2], 18);
         x[ 3] ^= rl(x[15] + x[11],  7);  x[ 7] ^= rl(x[ 3] + x[15],  9);
         x[11] ^= rl(x[ 7] + x[ 3], 13);  x[15] ^= rl(x[11] + x[ 7], 18);
         x[ 1] ^= rl(x[ 0] + x[ 3],  7);  x[ 2] ^= rl(x[ 1] + x[ 0],  9);
         x[ 3] ^= rl(x[ 2] + x[ 1], 13);  x[ 0] ^= rl(x[ 3] + x[ 2], 18);
         x[ 6] ^= rl(x[ 5] + x[ 4],  7);  x[ 7] ^= rl(x[ 6] + x[ 5],  9);
         x[ 4] ^= rl(x[ 7] + x[ 6], 13);  x[ 5] ^= rl(x[ 4] + x[ 7], 18);
         x[11] ^= rl(x[10] + x[ 9],  7);  x[ 8] ^= rl(x[11] + x[10],  9);
         x[ 9] ^= rl(x[ 8] + x[11], 13);  x[10] ^= rl(x[ 9] + x[ 8], 18);
         x[12] ^= rl(x[15] + x[14],  7);  x[13] ^= rl(x[12] + x[15],  9);
         x[14] ^= rl(x[13] + x[12], 13);  x[15] ^= rl(x[14] + x[13], 18);
      end
      for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + blk[32*i +: 32];
      return res;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // Scoreboard: expected results and accept cycles for the ROUNDS=8 instance
   logic [511:0] exp_q [$];
   int unsigned  acc_q [$];
   logic         prev_ov = 1'b0;
   bit           b2b_mode = 1'b0;
   int unsigned  b2b_n = 0;
   int unsigned  last_acc = 0;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov = 1'b0;
      end else begin
         if (bus.out_valid && !prev_ov) begin
            check("acc_pending", 512'(acc_q.size() != 0), 512'(1));
            if (acc_q.size() != 0) check("latency", 512'(cyc - acc_q[0]), 512'(R1));
         end
         if (bus.out_valid && bus.out_ready) begin
            check("exp_pending", 512'(exp_q.size() != 0), 512'(1));
            if (exp_q.size() != 0) begin
               check("model_data", bus.out_data, exp_q.pop_front());
               if (acc_q.size() != 0) void'(acc_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(salsa_ref(bus.in_data, R1));
            acc_q.push_back(cyc + 1);
            if (b2b_mode) begin
               if (b2b_n > 0) check("spacing", 512'(cyc + 1 - last_acc), 512'(R1 + 2));
               b2b_n++;
            end
            last_acc = cyc + 1;
         end
         prev_ov = bus.out_valid;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [511:0] d);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 512'(bus.in_ready), 512'(1));
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = rand_block();
   endtask

   task automatic wait_out();
      int n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("out_wait", 512'(bus.out_valid), 512'(1));
   endtask

   initial begin
      logic [511:0] kat_in, kat_out, blk_a, blk_b, snap, d2;
      int           n, k, lat;

      for (int j = 0; j < 64; j++) begin
         kat_in[8*j +: 8]  = kat_in_b[j];
         kat_out[8*j +: 8] = kat_out_b[j];
      end

      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 512'(bus.out_valid), 512'(0));
      check("rst_out_data", bus.out_data, '0);
      check("rst_busy", 512'(bus.busy), 512'(0));
      check("rst_in_ready", 512'(bus.in_ready), 512'(1));
      rst_n = 1'b1;
      @(negedge clk);

      // Zero block is a fixed point
      send('0);
      check("zero_busy", 512'(bus.busy), 512'(1));
      wait_out();
      check("zero_data", bus.out_data, '0);
      @(negedge clk);
      check("zero_in_ready", 512'(bus.in_ready), 512'(1));
      check("zero_ov_drop", 512'(bus.out_valid), 512'(0));

      // RFC 7914 known answer
      send(kat_in);
      wait_out();
      check("kat", bus.out_data, kat_out);
      @(negedge clk);

      // Backpressure with a competing input held
      bus.out_ready = 1'b0;
      blk_a = rand_block();
      blk_b = rand_block();
      send(blk_a);
      wait_out();
      snap = bus.out_data;
      check("bp_first", snap, salsa_ref(blk_a, R1));
      bus.in_valid = 1'b1;
      bus.in_data  = blk_b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", 512'(bus.out_valid), 512'(1));
         check("bp_hold_data", bus.out_data, snap);
         check("bp_in_ready", 512'(bus.in_ready), 512'(0));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_released", 512'(bus.out_valid), 512'(0));
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_out();
      check("bp_second", bus.out_data, salsa_ref(blk_b, R1));
      @(negedge clk);

      // Reset in the middle of a block
      send(rand_block());
      repeat (4) @(negedge clk);
      check("mid_busy", 512'(bus.busy), 512'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_out_valid", 512'(bus.out_valid), 512'(0));
      check("mid_out_data", bus.out_data, '0);
      check("mid_in_ready", 512'(bus.in_ready), 512'(1));
      check("mid_busy_clr", 512'(bus.busy), 512'(0));
      blk_a = rand_block();
      send(blk_a);
      wait_out();
      check("mid_result", bus.out_data, salsa_ref(blk_a, R1));
      @(negedge clk);

      // Back-to-back random blocks
      b2b_mode = 1'b1;
      k = 0;
      n = 0;
      while (k < 100 && n < 3000) begin
         @(negedge clk);
         n++;
         if (bus.in_ready) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_block();
            k++;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("b2b_count", 512'(k), 512'(100));
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_drain", 512'(exp_q.size()), 512'(0));
      b2b_mode = 1'b0;

      // ROUNDS=2 instance: one double round plus feed-forward
      d2 = 512'd1;
      check("r2_in_ready", 512'(bus2.in_ready), 512'(1));
      bus2.in_valid = 1'b1;
      bus2.in_data  = d2;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      bus2.in_data  = rand_block();
      lat = 0;
      while (!bus2.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("r2_latency", 512'(lat), 512'(2));
      check("r2_data", bus2.out_data, salsa_ref(d2, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/salsa20_8_core.md
Name: salsa20_8_core

Overview:
- Iterative Salsa20/8 core function: accepts one 512-bit block, runs the double-round schedule with four parallel quarter-round units, adds the input block back in (feed-forward), and returns the 512-bit result.
- Sits between the BlockMix sequencer, which is upstream and does the X xor B[i] input preparation, and the BlockMix output buffer, which is downstream.
- One half-round (column round or row round) is executed per clock cycle.
- Valid/ready handshakes are used on both sides.

Parameters:
- ROUNDS, 8: number of Salsa rounds. Must be even and ≥2. Total compute cycles = ROUNDS.
- CNT_W, 4: round counter width. Must satisfy 2^CNT_W > ROUNDS.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core can accept a block.
- in_data  in  512  input block. Word i = in_data[32i+31:32i], i = 0..15.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  512  result block, same word packing as in_data.
- busy  out  1  high in ROUND state.

Behaviour:
- **Reset** (rst_n=0 sampled at a rising edge, regardless of state):
  - state=IDLE, round counter=0.
  - out_valid=0, out_data=0, busy=0.
  - Working state x[0..15]=0, saved input copy=0.
  - in_ready goes high in the first cycle after rst_n returns high.
  - A block in flight is discarded and no partial result is emitted.
- **States:** IDLE, ROUND, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==ROUND).
  - out_valid = (state==DONE).
- **IDLE:**
  - On in_valid && in_ready: load x[i] and the saved copy z[i] from in_data, set counter=0, go to ROUND.
  - in_data is sampled only on this edge; upstream may change it afterwards.
- **ROUND:** each edge applies one half-round to x.
  - counter even → column round.
  - counter odd → row round.
  - counter increments by 1 per edge.
- **Quarterround(a,b,c,d)**, all arithmetic mod 2^32, rotl = rotate left:
  - b ^= rotl(a+d,7)
  - c ^= rotl(b+a,9)
  - d ^= rotl(c+b,13)
  - a ^= rotl(d+c,18)
- **Column round:** four quarterrounds in parallel on (a,b,c,d) =
  - (x0,x4,x8,x12)
  - (x5,x9,x13,x1)
  - (x10,x14,x2,x6)
  - (x15,x3,x7,x11)
- **Row round:** four quarterrounds in parallel on (a,b,c,d) =
  - (x0,x1,x2,x3)
  - (x5,x6,x7,x4)
  - (x10,x11,x8,x9)
  - (x15,x12,x13,x14)
- **Final round and feed-forward:** on the edge where counter==ROUNDS-1:
  - Compute the final half-round result r.
  - Register out_data word i = r[i] + z[i] (mod 2^32, no carry between words).
  - Go to DONE.
- **Latency:** if the input handshake occurs at edge N, out_valid is high from edge N+ROUNDS onward (8 cycles for the default).
- **DONE:**
  - out_data and out_valid are held stable while out_ready=0.
  - On out_ready=1: out_valid drops at that edge and the core goes to IDLE.
  - The next input can be accepted at the following edge.
  - Throughput: one block per ROUNDS+2 cycles minimum.
- **Handshake boundaries:**
  - in_valid while in ROUND or DONE is ignored (in_ready=0); upstream must hold.
  - out_ready while not in DONE has no effect.
  - in_valid and out_ready both high in DONE: only the output handshake completes that cycle.
- **Counter:** saturates logically because the state leaves ROUND at ROUNDS-1. The counter is never read outside ROUND.
- **Arithmetic:** all adds are 32-bit modular with carry-out discarded. Rotations are pure wiring.

Test Plan:
- **Zero block:** in_data=0 with out_ready=1 → out_valid after 8 cycles, out_data=0 (zero is a Salsa fixed point); in_ready high again one cycle after the output handshake.
- **Known answer:** RFC 7914 §8 Salsa20/8 input vector (7e879a21…) → out_data equals the RFC output (a41f859c…) word-for-word. Check little-endian byte-to-word packing.
- **Backpressure:** out_ready=0 for 20 cycles after completion → out_valid stays 1, out_data is unchanged, in_ready stays 0, and a second in_valid pulse is not accepted. Raise out_ready → handshake completes, then the second block is accepted and produces its own correct result.
- **Reset mid-operation:** assert rst_n=0 for 1 cycle at round 4 → the next cycle shows out_valid=0, out_data=0, in_ready=1. A new block then completes in exactly 8 cycles with the correct result.
- **Back-to-back:** 100 random blocks with in_valid and out_ready held at 1 → each output matches the software model, and the spacing between accepts is exactly ROUNDS+2=10 cycles.
- **ROUNDS=2:** single-word input (x0=1, others 0) → out_data matches a one-double-round reference model plus feed-forward; latency is 2 cycles.
